// File: rtl/online_arith_pkg.sv
// Shared types and digit-range helpers for the radix-2^k online adder.
package online_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int DEF_RADIX_LOG2 = 2;

    function automatic int digit_w(input int radix_log2);
        return radix_log2 + 1;
    endfunction

    function automatic int digit_max(input int radix_log2);
        return (1 << radix_log2) - 1;
    endfunction

    function automatic int digit_min(input int radix_log2);
        return -((1 << radix_log2) - 1);
    endfunction

    localparam int DEF_DIGIT_W   = digit_w(DEF_RADIX_LOG2);
    localparam int DEF_DIGIT_MAX = digit_max(DEF_RADIX_LOG2);
    localparam int DEF_DIGIT_MIN = digit_min(DEF_RADIX_LOG2);

endpackage

// File: rtl/online_digit_slice.sv
// Splits a signed-digit pair sum into transfer t in {-1,0,1} and interim w.
module online_digit_slice
    import online_arith_pkg::*;
#(
    parameter int RADIX_LOG2 = 2
) (
    input  logic [RADIX_LOG2:0] x,
    input  logic [RADIX_LOG2:0] y,
    output logic [1:0]          t,
    output logic [RADIX_LOG2:0] w
);

    localparam int DW = digit_w(RADIX_LOG2);
    localparam logic signed [DW:0] HI = (DW+1)'(digit_max(RADIX_LOG2));
    localparam logic signed [DW:0] LO = (DW+1)'(digit_min(RADIX_LOG2));
    localparam logic signed [DW:0] R  = (DW+1)'(1 << RADIX_LOG2);

    logic signed [DW:0] s;
    logic signed [DW:0] d;

    always_comb begin
        s = $signed({x[DW-1], x}) + $signed({y[DW-1], y});
        d = s;
        t = 2'b00;
        if (s >= HI) begin
            t = 2'b01;
            d = s - R;
        end else if (s <= LO) begin
            t = 2'b11;
            d = s + R;
        end
        w = d[DW-1:0];
    end

endmodule

// File: rtl/online_serial_adder.sv
// Online (MSD-first) signed-digit adder, delay 1, valid/ready on both sides.
// Optional carry-in on the flush digit: define ONLINE_ADDER_CIN_EN.
module online_serial_adder
    import online_arith_pkg::*;
#(
    parameter int N_DIGITS   = 8,
    parameter int RADIX_LOG2 = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [RADIX_LOG2:0] din1,
    input  logic [RADIX_LOG2:0] din2,
`ifdef ONLINE_ADDER_CIN_EN
    input  logic [1:0]          cin,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RADIX_LOG2:0] dout,
    output logic                dout_first,
    output logic                dout_last
);

    localparam int DW = digit_w(RADIX_LOG2);
    localparam int CW = $clog2(N_DIGITS + 1);
    localparam logic [CW-1:0] LAST = CW'(N_DIGITS - 1);

    if (RADIX_LOG2 < 2) begin : g_bad_radix
        $error("online_serial_adder: RADIX_LOG2 must be >= 2");
    end
    if (N_DIGITS < 1) begin : g_bad_ndig
        $error("online_serial_adder: N_DIGITS must be >= 1");
    end

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [DW-1:0]   w_q, w_n;
    logic [DW-1:0]   dout_n;
    logic            ov_n, first_n, last_n;
    logic [1:0]      t;
    logic [DW-1:0]   w;
    logic [DW-1:0]   t_x;
    logic [DW-1:0]   cin_x;
    logic            out_free;
    logic            acc;
    logic            acc_last;

    online_digit_slice #(
        .RADIX_LOG2(RADIX_LOG2)
    ) u_slice (
        .x(din1),
        .y(din2),
        .t(t),
        .w(w)
    );

`ifdef ONLINE_ADDER_CIN_EN
    logic [1:0] cin_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cin_q <= 2'b00;
        end else if (acc_last) begin
            cin_q <= cin;
        end
    end

    assign cin_x = {{(DW-2){cin_q[1]}}, cin_q};
`else
    assign cin_x = '0;
`endif

    assign t_x      = {{(DW-2){t[1]}}, t};
    assign out_free = !out_valid || out_ready;
    assign in_ready = (state != FLUSH) && out_free;
    assign acc      = in_valid && in_ready;
    assign acc_last = acc && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            w_q        <= '0;
            out_valid  <= 1'b0;
            dout       <= '0;
            dout_first <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            w_q        <= w_n;
            out_valid  <= ov_n;
            dout       <= dout_n;
            dout_first <= first_n;
            dout_last  <= last_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        w_n     = w_q;
        ov_n    = out_valid && !out_ready;
        dout_n  = dout;
        first_n = dout_first;
        last_n  = dout_last;
        unique case (state)
            IDLE: begin
                if (acc) begin
                    dout_n  = t_x;
                    first_n = 1'b1;
                    last_n  = 1'b0;
                    ov_n    = 1'b1;
                    w_n     = w;
                    cnt_n   = cnt + 1'b1;
                    state_n = (cnt == LAST) ? FLUSH : RUN;
                end
            end
            RUN: begin
                if (acc) begin
                    dout_n  = w_q + t_x;
                    first_n = 1'b0;
                    last_n  = 1'b0;
                    ov_n    = 1'b1;
                    w_n     = w;
                    cnt_n   = cnt + 1'b1;
                    state_n = (cnt == LAST) ? FLUSH : RUN;
                end
            end
            FLUSH: begin
                if (out_free) begin
                    dout_n  = w_q + cin_x;
                    first_n = 1'b0;
                    last_n  = 1'b1;
                    ov_n    = 1'b1;
                    w_n     = '0;
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_online_serial_adder.sv
// Scoreboard bench for online_serial_adder at r=4, N_DIGITS=4.
module tb_online_serial_adder;

    localparam int NDIG = 4;
    localparam int RL   = 2;

    typedef int vec4_t[4];
    typedef int vec5_t[5];
    typedef struct {
        int d;
        bit f;
        bit l;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] din1;
    logic [2:0] din2;
    logic [1:0] cin;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] dout;
    logic       dout_first;
    logic       dout_last;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b1;
    int   cyc      = 0;

    online_serial_adder #(
        .N_DIGITS(NDIG),
        .RADIX_LOG2(RL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .din1(din1),
        .din2(din2),
`ifdef ONLINE_ADDER_CIN_EN
        .cin(cin),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dout(dout),
        .dout_first(dout_first),
        .dout_last(dout_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (mon_en && !rst && out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out dout=%0d first=%0b last=%0b",
                         $signed(dout), dout_first, dout_last);
            end else begin
                e = q.pop_front();
                if ($signed(dout) != e.d || dout_first != e.f || dout_last != e.l) begin
                    failures++;
                    $display("FAIL digit got=%0d/%0b/%0b want=%0d/%0b/%0b",
                             $signed(dout), dout_first, dout_last, e.d, e.f, e.l);
                end
            end
        end
    end

    task automatic push_frame(input vec5_t d);
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            e.d = d[i];
            e.f = (i == 0);
            e.l = (i == 4);
            q.push_back(e);
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic send_digit(input int a, input int b, output int acc_cyc);
        int n;
        in_valid = 1'b1;
        din1 = 3'(a);
        din2 = 3'(b);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout got=in_ready_low want=accept");
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input vec4_t a, input vec4_t b, output int t0);
        int tc;
        for (int k = 0; k < 4; k++) begin
            send_digit(a[k], b[k], tc);
            if (k == 0) t0 = tc;
        end
    endtask

    initial begin
        vec4_t x1 = '{1, 2, 3, 0};
        vec4_t y1 = '{2, 1, 0, 3};
        vec5_t r1 = '{1, 0, 0, 0, -1};
        vec4_t xn = '{-3, -3, -3, -3};
        vec5_t rn = '{-1, -3, -3, -3, -2};
        vec4_t z4 = '{0, 0, 0, 0};
        vec5_t z5 = '{0, 0, 0, 0, 0};
        vec4_t x3 = '{3, -1, 2, 0};
        vec4_t y3 = '{0, 1, -2, 1};
        vec5_t r3 = '{1, -1, 0, 0, 1};
        vec4_t x4 = '{1, -2, 2, -3};
        vec4_t y4 = '{1, -1, 0, 3};
        vec5_t r4 = '{0, 1, 1, 2, 0};
        int ta, tb, tc, n;

        in_valid  = 1'b0;
        din1      = '0;
        din2      = '0;
        cin       = 2'b00;
        out_ready = 1'b1;
        rst       = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_dout", int'(dout), 0);
        check("reset_first_last", int'({dout_first, dout_last}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        push_frame(r1);
        send_frame(x1, y1, ta);
        push_frame(rn);
        send_frame(xn, xn, ta);
        push_frame(r3);
        send_frame(x3, y3, ta);
        push_frame(r4);
        send_frame(x4, y4, ta);

        push_frame(z5);
        send_frame(z4, z4, ta);
        push_frame(z5);
        send_frame(z4, z4, tb);
        check("frame_time", tb - ta, 5);

        push_frame(r1);
        send_digit(1, 2, tc);
        send_digit(2, 1, tc);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        din1 = 3'd3;
        din2 = 3'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_dout", int'($signed(dout)), 0);
            check("stall_valid", int'(out_valid), 1);
            check("stall_in_ready", int'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_digit(3, 0, tc);
        send_digit(0, 3, tc);

        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        send_digit(1, 2, tc);
        send_digit(2, 1, tc);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", int'(out_valid), 0);
        check("async_rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        push_frame(r1);
        send_frame(x1, y1, ta);

`ifdef ONLINE_ADDER_CIN_EN
        push_frame('{1, 0, 0, 0, 0});
        cin = 2'b01;
        send_frame(x1, y1, ta);
`endif

        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
